nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencing controller that performs wide add/subtract by time-multiplexing one 4-bit ripple adder slice over NIBBLES cycles, least significant nibble first. It holds a registered carry between slices and gives callers a start/ready/done handshake. It sits between control logic needing wide arithmetic and the shared 4-bit adder datapath. The slice instance lives inside this block.

Parameters:
NIBBLES, 4, operand width in 4-bit slices (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only on a rising edge where ready=1.
sub  input  1  0 = a+b+carry_in; 1 = a-b (carry_in ignored).
op_a  input  W  operand A; sampled only at accept.
op_b  input  W  operand B; sampled only at accept.
carry_in  input  1  add-mode carry in; sampled at accept.
ready  output  1  block can accept start.
done  output  1  one-cycle pulse: result fields valid.
result  output  W  sum/difference; held until next accept.
carry_out  output  1  final slice carry. In sub mode, 1 = no borrow.
overflow  output  1  signed two's-complement overflow of final result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, result=0, carry_out=0, overflow=0, slice counter=0, carry register=0, operand registers=0.
- States:
  - IDLE: ready=1. Accept moves to ADD.
  - ADD: ready=0. One slice per cycle.
  - DONE: ready=1, done=1. Lasts exactly one cycle.
- Accept (start=1 and ready=1 at an edge):
  - Latch op_a into a_reg.
  - Latch op_b into b_reg, bitwise inverted when sub=1.
  - Latch sub into sub_reg.
  - Carry register loads 1 if sub=1, else carry_in.
  - Counter loads 0. Go to ADD.
  - Result fields are not cleared at accept.
- ADD, each cycle with counter k:
  - Adder inputs are a_reg[4k+3:4k], b_reg[4k+3:4k] and the carry register.
  - At the edge, write the slice sum into result[4k+3:4k] and update the carry register from the slice carry.
  - If k = NIBBLES-1: go to DONE and register carry_out and overflow. Otherwise increment the counter.
- overflow = (a_reg[W-1] == b_reg[W-1]) && (sum bit W-1 != a_reg[W-1]), where b_reg is the post-inversion value.
- Latency: accept at edge E0 → done high in the cycle after edge E_NIBBLES → total NIBBLES+1 cycles from accept to end of done.
- Back-to-back: start while in DONE is accepted (DONE→ADD). The done pulse still lasts exactly that one cycle.
- start while in ADD is ignored. It is not queued and causes no error.
- Operand inputs may change freely after accept; the block uses only the latched copies.
- DONE without start → IDLE.
- result, carry_out and overflow hold their values in IDLE and remain stable until the next accept. During ADD, result updates nibble by nibble.
- Reset asserted mid-operation clears everything immediately (asynchronously) to the reset values. No done pulse is produced. The first accept after reset release behaves normally.
- Wrap-around: the counter never exceeds NIBBLES-1. Add/sub results are modulo 2^W, with carry reported on carry_out.

Test Plan:
(All with NIBBLES=4.)
1. Add 0x1234 + 0x0FCD, carry_in=0 → done 5 cycles after accept; result=0x2201, carry_out=0, overflow=0; ready low for exactly 4 cycles.
2. Add 0xFFFF + 0x0001, carry_in=0 → result=0x0000, carry_out=1, overflow=0. Repeat with carry_in=1 → result=0x0001, carry_out=1.
3. Sub 0x0005 - 0x0007 → result=0xFFFE, carry_out=0 (borrow), overflow=0. Then sub 0x8000 - 0x0001 → result=0x7FFF, carry_out=1, overflow=1.
4. Add 0x7FFF + 0x0001 → result=0x8000, overflow=1. Pulse start with other operands during ADD → ignored; result unchanged; only one done pulse.
5. Back-to-back: assert start during DONE with 0x0001+0x0002 → accepted, next done shows 0x0003. Previous result stays stable until that accept.
6. Assert reset during ADD cycle 2 → all outputs 0 and ready=1 immediately (asynchronously, before the next clk edge); no done pulse. A fresh add 0x00FF+0x0001 then gives 0x0100.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract controller that reuses one 4-bit ripple slice over NIBBLES cycles,
// least significant nibble first, with a start/ready/done handshake.

module nibble_adder_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    logic c;

    always_comb begin
        // NOTE: blocking assignments are correct here; the carry ripples bit to bit within one evaluation.
        c     = c_i;
        sum_o = '0;
        for (int i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        c_o = c;
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   carry_in,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow
);
    localparam int             CW   = $clog2(NIBBLES);
    localparam logic [CW-1:0]  LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NIBBLES-1:0][3:0]    a_q, a_d;
    logic [NIBBLES-1:0][3:0]    b_q, b_d;
    logic [NIBBLES-1:0][3:0]    result_q, result_d;
    logic                       sub_q, sub_d;
    logic                       carry_q, carry_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       carry_out_q, carry_out_d;
    logic                       overflow_q, overflow_d;

    logic [3:0]                 slice_sum;
    logic                       slice_carry;

    nibble_adder_slice u_slice (
        .a_i   (a_q[cnt_q]),
        .b_i   (b_q[cnt_q]),
        .c_i   (carry_q),
        .sum_o (slice_sum),
        .c_o   (slice_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no latches are inferred.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; result fields are deliberately left untouched.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : carry_in;
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                result_d[cnt_q] = slice_sum;
                carry_d         = slice_carry;
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    carry_out_d = slice_carry;
                    overflow_d  = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                                  (slice_sum[3] != a_q[NIBBLES-1][3]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready     = (state_q != ADD);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (NIBBLES=4): vector table plus
// hand-written sequences for start-during-ADD, back-to-back and mid-operation reset.

module tb_nibble_serial_adder_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int tests  = 0;
    int failed = 0;
    logic [W-1:0] last_exp = '0;

    typedef struct {
        string        name;
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_res;
        logic         exp_c;
        logic         exp_v;
    } vec_t;

    vec_t vecs [9];

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with ready=1; returns at the negedge where done is observed.
    task automatic do_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] er, input logic ec, input logic ev);
        int  lat;
        int  rdy_low;
        bit  seen;
        start = 1'b1; sub = s; op_a = a; op_b = b; carry_in = ci;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); carry_in = ~ci; sub = ~s;
        check({tag, " result held at accept"}, 32'(result), 32'(last_exp));
        lat = 0; rdy_low = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (!ready) rdy_low++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " ready low cycles"}, 32'(rdy_low), 32'd4);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " carry_out"}, 32'(carry_out), 32'(ec));
        check({tag, " overflow"}, 32'(overflow), 32'(ev));
        last_exp = er;
    endtask

    initial begin
        int pulses;
        int first;

        vecs[0] = '{"add_1234_0fcd",  1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{"add_ffff_1",     1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"add_ffff_1_ci",  1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[3] = '{"sub_5_7",        1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_8000_1",     1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"add_7fff_1",     1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{"sub_7_7",        1'b1, 16'h0007, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{"sub_ci_ignored", 1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[8] = '{"add_8000_8000",  1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset carry_out", 32'(carry_out), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            do_op(vecs[v].name, vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].ci,
                  vecs[v].exp_res, vecs[v].exp_c, vecs[v].exp_v);
            @(negedge clk);
            check({vecs[v].name, " done one cycle"}, 32'(done), 32'd0);
            check({vecs[v].name, " idle ready"}, 32'(ready), 32'd1);
            check({vecs[v].name, " result held idle"}, 32'(result), 32'(vecs[v].exp_res));
        end

        // start pulsed during ADD must be ignored
        start = 1'b1; sub = 1'b0; op_a = 16'h7FFF; op_b = 16'h0001; carry_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0; first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 2) begin
                start = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore start pulses", 32'(pulses), 32'd1);
        check("ignore start latency", 32'(first), 32'd5);
        check("ignore start result", 32'(result), 32'h8000);
        check("ignore start overflow", 32'(overflow), 32'd1);
        last_exp = 16'h8000;

        // back-to-back: second accept happens in the DONE cycle of the first
        do_op("b2b first", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        do_op("b2b second", 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b done drop", 32'(done), 32'd0);

        // asynchronous reset in the middle of ADD
        start = 1'b1; sub = 1'b0; op_a = 16'hAAAA; op_b = 16'h1111; carry_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        check("partial result before reset", 32'(result), 32'h000B);
        reset = 1'b1;
        #1;
        check("async reset ready", 32'(ready), 32'd1);
        check("async reset done", 32'(done), 32'd0);
        check("async reset result", 32'(result), 32'd0);
        check("async reset carry_out", 32'(carry_out), 32'd0);
        check("async reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_exp = '0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no done after reset", 32'(pulses), 32'd0);
        do_op("post reset", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
